// File: rtl/comp_nbit_seq_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package comp_nbit_seq_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmp  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit positions within the {eq, gt, lt} result code.
  localparam int unsigned ZEq = 2;
  localparam int unsigned ZGt = 1;
  localparam int unsigned ZLt = 0;

  // One-hot result codes.
  localparam logic [2:0] REq = 3'b100;
  localparam logic [2:0] RGt = 3'b010;
  localparam logic [2:0] RLt = 3'b001;

  // Map a pair of magnitude flags onto the one-hot code; equal when neither is set.
  function automatic logic [2:0] result_code(input logic gt, input logic lt);
    logic [2:0] code;
    code = REq;
    if (gt) begin
      code = RGt;
    end else if (lt) begin
      code = RLt;
    end
    return code;
  endfunction

endpackage

// File: rtl/comp_nbit_seq_if.sv
// Handshake bundle: operand/mode input channel, result output channel and status.
interface comp_nbit_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       z;
  logic             busy;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, z, busy
  );

  // Comparator side.
  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, z, busy
  );
endinterface

// File: rtl/comp_nbit_seq_comp_digit.sv
// Combinational compare of one DIGIT-bit slice pair, giving the one-hot {eq, gt, lt} code.
module comp_digit
  import comp_nbit_seq_pkg::*;
#(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic [2:0]       z_o
);

  // Unsigned slice compare.
  always_comb begin
    z_o = result_code(a_i > b_i, a_i < b_i);
  end

endmodule

// File: rtl/comp_nbit_seq.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first one slice per clock and
// stops at the first differing slice. Signed mode flips both sign bits on capture so the
// unsigned slice compare orders two's-complement values correctly.
module comp_nbit_seq
  import comp_nbit_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  comp_nbit_seq_if.slave  bus_io
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(NDIG - 1);

  if ((WIDTH < DIGIT) || (WIDTH % DIGIT != 0)) begin : gen_bad_params
    $error("WIDTH must be a non-zero multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IdxW-1:0]  idx_q;
  logic [2:0]       z_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] sign_flip;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [2:0]       dig_res;

  // Slice selection and sign-bit mask for operand capture.
  always_comb begin
    sign_flip            = '0;
    sign_flip[WIDTH-1]   = bus_io.signed_mode;
    a_dig                = a_q[idx_q*DIGIT +: DIGIT];
    b_dig                = b_q[idx_q*DIGIT +: DIGIT];
  end

  comp_digit #(
    .DIGIT (DIGIT)
  ) u_comp_digit (
    .a_i (a_dig),
    .b_i (b_dig),
    .z_o (dig_res)
  );

  // Controller: capture, slice walk, result hold until the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      z_q         <= 3'b000;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.in_valid) begin
            a_q     <= bus_io.a ^ sign_flip;
            b_q     <= bus_io.b ^ sign_flip;
            idx_q   <= IdxTop;
            state_q <= StCmp;
          end
        end
        StCmp: begin
          if (!dig_res[ZEq]) begin
            z_q         <= dig_res;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else if (idx_q == '0) begin
            z_q         <= REq;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StDone: begin
          if (bus_io.out_ready) begin
            z_q         <= 3'b000;
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Status and result outputs, all decoded from registered state.
  always_comb begin
    bus_io.in_ready  = (state_q == StIdle);
    bus_io.busy      = (state_q == StCmp);
    bus_io.out_valid = out_valid_q;
    bus_io.z         = z_q;
  end

endmodule

// File: tb/tb_comp_nbit_seq.sv
// Self-checking bench for comp_nbit_seq (WIDTH=8, DIGIT=2) against an arithmetic model.
module tb_comp_nbit_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIGIT = 2;
  localparam int unsigned NDIG  = WIDTH / DIGIT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  comp_nbit_seq_if #(.WIDTH(WIDTH)) bus ();

  comp_nbit_seq #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] exp_z_g  = 3'b000;
  bit         track    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: plain integer ordering of the operands.
  function automatic logic [2:0] model_z(input logic [7:0] a, input logic [7:0] b, input bit mode);
    int ia, ib;
    if (mode) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    if (ia == ib) return 3'b100;
    if (ia > ib) return 3'b010;
    return 3'b001;
  endfunction

  // Reference latency: position (from MSB, 1-based) of the first differing slice.
  function automatic int model_k(input logic [7:0] a, input logic [7:0] b);
    int mask, lo;
    mask = (1 << DIGIT) - 1;
    for (int i = 0; i < int'(NDIG); i++) begin
      lo = int'(WIDTH) - int'(DIGIT) * (i + 1);
      if (((int'(a) >> lo) & mask) != ((int'(b) >> lo) & mask)) return i + 1;
    end
    return int'(NDIG);
  endfunction

  // Per-cycle compare: result matches model, one-hot when valid, zero otherwise.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      check("z_onehot", 32'($onehot(bus.z)), 32'd1);
      if (track) check("z_model", 32'(bus.z), 32'(exp_z_g));
    end else begin
      check("z_zero_when_invalid", 32'(bus.z), 32'd0);
    end
    check("busy_ready_exclusive", 32'(bus.busy & bus.in_ready), 32'd0);
  end

  task automatic wait_ready(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_in_ready"}, 32'(seen), 32'd1);
  endtask

  // One full transaction: offer, measure latency, hold for gap cycles, hand off.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input bit mode,
                         input int gap, input bit noise, input logic [2:0] exp_z,
                         input int exp_k, input string tag);
    int lat;
    wait_ready(tag);
    bus.in_valid    = 1'b1;
    bus.a           = a;
    bus.b           = b;
    bus.signed_mode = mode;
    @(posedge clk);
    exp_z_g = exp_z;
    track   = 1'b1;
    #1;
    // Ignored inputs while busy: scrambled operands and, optionally, early out_ready.
    bus.in_valid    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.a           = 8'($urandom);
    bus.b           = 8'($urandom);
    bus.signed_mode = 1'($urandom_range(0, 1));
    lat = 0;
    for (int j = 1; j <= int'(NDIG) + 2; j++) begin
      if (noise) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = j;
        break;
      end
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end
    bus.out_ready = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_k));
    check({tag, "_z"}, 32'(bus.z), 32'(exp_z));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    track         = 1'b0;
    check({tag, "_valid_clear"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    bit         rm;
    int         sel;

    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;

    // Reset state.
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_z", 32'(bus.z), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Pin the model with hand-computed results.
    check("pin_eq_z", 32'(model_z(8'hA5, 8'hA5, 1'b0)), 32'h4);
    check("pin_eq_k", 32'(model_k(8'hA5, 8'hA5)), 32'd4);
    check("pin_u80_z", 32'(model_z(8'h80, 8'h7F, 1'b0)), 32'h2);
    check("pin_s80_z", 32'(model_z(8'h80, 8'h7F, 1'b1)), 32'h1);
    check("pin_12_k", 32'(model_k(8'h12, 8'h13)), 32'd4);
    check("pin_sFE_z", 32'(model_z(8'hFE, 8'h01, 1'b1)), 32'h1);

    // Directed scenarios with literal expectations.
    run_txn(8'hA5, 8'hA5, 1'b0, 0, 1'b0, 3'b100, 4, "eq_a5");
    run_txn(8'h80, 8'h7F, 1'b0, 1, 1'b0, 3'b010, 1, "u80_7f");
    run_txn(8'h80, 8'h7F, 1'b1, 0, 1'b0, 3'b001, 1, "s80_7f");
    run_txn(8'h12, 8'h13, 1'b0, 2, 1'b0, 3'b001, 4, "u12_13");
    run_txn(8'hFE, 8'h01, 1'b1, 0, 1'b0, 3'b001, 1, "sFE_01");

    // Backpressure with new operands offered throughout.
    wait_ready("bp");
    bus.in_valid = 1'b1;
    bus.a        = 8'h12;
    bus.b        = 8'h13;
    bus.signed_mode = 1'b0;
    @(posedge clk);
    exp_z_g = 3'b001;
    track   = 1'b1;
    #1;
    bus.a = 8'hC0;
    bus.b = 8'h3F;
    repeat (4) @(posedge clk);
    #1;
    check("bp_result_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_z", 32'(bus.z), 32'h1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    exp_z_g = model_z(8'hC0, 8'h3F, 1'b0);
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_accept_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    check("bp_new_valid", 32'(bus.out_valid), 32'd1);
    check("bp_new_z", 32'(bus.z), 32'h2);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    track = 1'b0;
    check("bp_new_clear", 32'(bus.out_valid), 32'd0);

    // Reset during the second compare cycle.
    wait_ready("rst_mid");
    bus.in_valid = 1'b1;
    bus.a        = 8'hA5;
    bus.b        = 8'hA5;
    bus.signed_mode = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_z", 32'(bus.z), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("rst_mid_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Randomised sweep, biased towards equal and near-equal operands.
    for (int n = 0; n < 1000; n++) begin
      ra  = 8'($urandom);
      sel = int'($urandom_range(0, 3));
      if (sel == 0) rb = ra;
      else if (sel == 1) rb = ra ^ (8'd1 << $urandom_range(0, 7));
      else rb = 8'($urandom);
      rm = 1'($urandom_range(0, 1));
      run_txn(ra, rb, rm, int'($urandom_range(0, 3)), 1'b1, model_z(ra, rb, rm),
              model_k(ra, rb), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
